// File: rtl/lii_pkg.sv
// Shared LII definitions: ID width, default packing width, header layout and the
// destination-match helper used by the receive filter.
package lii_pkg;

   localparam int LII_ID_W       = 8;
   localparam int LII_PW_DEFAULT = 64;

   typedef struct packed {
      logic [LII_ID_W-1:0] src;
      logic [LII_ID_W-1:0] dst;
   } lii_hdr_t;

   function automatic logic lii_id_match(input logic [LII_ID_W-1:0] dst,
                                         input logic [LII_ID_W-1:0] id);
      return dst == id;
   endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// First-word-fall-through synchronous FIFO: registered storage, combinational read at rd_ptr.
// Full/empty come from the level counter so the pointers can wrap naturally.
module lii_sync_fifo #(
   parameter int W     = 80,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wr_en_i,
   input  logic [W-1:0]           wr_data_i,
   input  logic                   rd_en_i,
   output logic [W-1:0]           rd_data_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push, pop;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign push      = wr_en_i && !full_o;
   assign pop       = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; contents are meaningless until written.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/lii_rx_filter_fifo.sv
// LII receive stage: keeps beats addressed to LOCAL_ID, buffers them in an FWFT FIFO
// and counts discarded beats with a saturating 16-bit counter.
module lii_rx_filter_fifo
   import lii_pkg::*;
#(
   parameter int                  PW            = LII_PW_DEFAULT,
   parameter int                  DEPTH         = 8,
   parameter logic [LII_ID_W-1:0] LOCAL_ID      = 8'h00,
   parameter bit                  DROP_MISMATCH = 1'b1
) (
   input  logic                   aclk,
   input  logic                   arst,
   input  logic [PW-1:0]          s_tdata,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic [LII_ID_W-1:0]    s_src,
   input  logic [LII_ID_W-1:0]    s_dst,
   output logic [PW-1:0]          m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [LII_ID_W-1:0]    m_src,
   output logic [LII_ID_W-1:0]    m_dst,
   output logic [$clog2(DEPTH):0] level,
   output logic [15:0]            drop_cnt
);

   localparam int W = PW + 2*LII_ID_W;

   lii_hdr_t      wr_hdr, rd_hdr;
   logic [W-1:0]  wr_data, rd_data;
   logic          fifo_full, fifo_empty;
   logic          accept, keep, push, drop;
   logic [15:0]   drop_cnt_q, drop_cnt_d;

   // Ready ignores dst on purpose: a full FIFO stalls mismatched beats too.
   assign s_tready = !arst && !fifo_full;
   assign accept   = s_tvalid && s_tready;
   assign keep     = !DROP_MISMATCH || lii_id_match(s_dst, LOCAL_ID);
   assign push     = accept && keep;
   assign drop     = accept && !keep;

   assign wr_hdr   = '{src: s_src, dst: s_dst};
   assign wr_data  = {wr_hdr, s_tdata};
   assign {rd_hdr, m_tdata} = rd_data;
   assign m_src    = rd_hdr.src;
   assign m_dst    = rd_hdr.dst;
   assign m_tvalid = !fifo_empty;
   assign drop_cnt = drop_cnt_q;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) drop_cnt_q <= '0;
      else      drop_cnt_q <= drop_cnt_d;
   end

   lii_sync_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (aclk),
      .rst_i     (arst),
      .wr_en_i   (push),
      .wr_data_i (wr_data),
      .rd_en_i   (m_tready),
      .rd_data_o (rd_data),
      .level_o   (level),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

endmodule

// File: tb/tb_lii_rx_filter_fifo.sv
// Scoreboard bench: instance A filters on dst 03 (depth 8), instance B has the filter off
// (depth 4). Drivers queue expected beats; negedge monitors compare whatever the DUTs present.
module tb_lii_rx_filter_fifo;

   localparam int DEPTH_A = 8;
   localparam int DEPTH_B = 4;
   localparam logic [7:0] ID = 8'h03;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  src;
      logic [7:0]  dst;
   } beat_t;

   logic        aclk = 1'b0;
   logic        arst = 1'b1;

   logic [63:0] s_tdataA = '0;
   logic        s_tvalidA = 1'b0, s_treadyA;
   logic [7:0]  s_srcA = '0, s_dstA = '0;
   logic [63:0] m_tdataA;
   logic        m_tvalidA, m_treadyA = 1'b0;
   logic [7:0]  m_srcA, m_dstA;
   logic [3:0]  levelA;
   logic [15:0] drop_cntA;

   logic [31:0] s_tdataB = '0;
   logic        s_tvalidB = 1'b0, s_treadyB;
   logic [7:0]  s_srcB = '0, s_dstB = '0;
   logic [31:0] m_tdataB;
   logic        m_tvalidB, m_treadyB = 1'b0;
   logic [7:0]  m_srcB, m_dstB;
   logic [2:0]  levelB;
   logic [15:0] drop_cntB;

   beat_t expA[$];
   beat_t expB[$];
   int    dropA = 0;
   int    dropB = 0;
   int    tests = 0;
   int    fails = 0;
   bit    doneB = 1'b0;

   always #5 aclk = ~aclk;

   lii_rx_filter_fifo #(.PW(64), .DEPTH(DEPTH_A), .LOCAL_ID(ID), .DROP_MISMATCH(1'b1)) dutA (
      .aclk(aclk), .arst(arst),
      .s_tdata(s_tdataA), .s_tvalid(s_tvalidA), .s_tready(s_treadyA),
      .s_src(s_srcA), .s_dst(s_dstA),
      .m_tdata(m_tdataA), .m_tvalid(m_tvalidA), .m_tready(m_treadyA),
      .m_src(m_srcA), .m_dst(m_dstA),
      .level(levelA), .drop_cnt(drop_cntA)
   );

   lii_rx_filter_fifo #(.PW(32), .DEPTH(DEPTH_B), .LOCAL_ID(ID), .DROP_MISMATCH(1'b0)) dutB (
      .aclk(aclk), .arst(arst),
      .s_tdata(s_tdataB), .s_tvalid(s_tvalidB), .s_tready(s_treadyB),
      .s_src(s_srcB), .s_dst(s_dstB),
      .m_tdata(m_tdataB), .m_tvalid(m_tvalidB), .m_tready(m_treadyB),
      .m_src(m_srcB), .m_dst(m_dstB),
      .level(levelB), .drop_cnt(drop_cntB)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int satInc(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic waitCycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   // Present one beat to A until accepted, then record the expected outcome.
   task automatic applyStimulusA(input logic [63:0] d, input logic [7:0] src, input logic [7:0] dst);
      bit acc = 1'b0;
      s_tdataA = d; s_srcA = src; s_dstA = dst; s_tvalidA = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge aclk);
         acc = s_treadyA;
         @(posedge aclk);
         #1;
      end
      s_tvalidA = 1'b0;
      if (!acc) checkOutput("A.accept_timeout", 64'd0, 64'd1);
      else if (dst == ID) expA.push_back('{data: d, src: src, dst: dst});
      else dropA = satInc(dropA);
   endtask

   // Filter is off on B, so every accepted beat must come out.
   task automatic applyStimulusB(input logic [31:0] d, input logic [7:0] src, input logic [7:0] dst);
      bit acc = 1'b0;
      s_tdataB = d; s_srcB = src; s_dstB = dst; s_tvalidB = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge aclk);
         acc = s_treadyB;
         @(posedge aclk);
         #1;
      end
      s_tvalidB = 1'b0;
      if (!acc) checkOutput("B.accept_timeout", 64'd0, 64'd1);
      else expB.push_back('{data: {32'd0, d}, src: src, dst: dst});
   endtask

   task automatic drainA();
      m_treadyA = 1'b1;
      for (int i = 0; i < 100 && levelA != 0; i++) waitCycles(1);
      checkOutput("A.drain", levelA, 0);
   endtask

   always @(negedge aclk) begin
      if (!arst) begin
         checkOutput("A.level", levelA, expA.size());
         checkOutput("A.m_tvalid", m_tvalidA, expA.size() != 0);
         checkOutput("A.s_tready", s_treadyA, expA.size() != DEPTH_A);
         checkOutput("A.drop_cnt", drop_cntA, dropA);
         if (m_tvalidA && expA.size() != 0) begin
            checkOutput("A.m_tdata", m_tdataA, expA[0].data);
            checkOutput("A.m_src", m_srcA, expA[0].src);
            checkOutput("A.m_dst", m_dstA, expA[0].dst);
            if (m_treadyA) void'(expA.pop_front());
         end
      end
   end

   always @(negedge aclk) begin
      if (!arst) begin
         checkOutput("B.level", levelB, expB.size());
         checkOutput("B.m_tvalid", m_tvalidB, expB.size() != 0);
         checkOutput("B.s_tready", s_treadyB, expB.size() != DEPTH_B);
         checkOutput("B.drop_cnt", drop_cntB, dropB);
         if (m_tvalidB && expB.size() != 0) begin
            checkOutput("B.m_tdata", m_tdataB, expB[0].data);
            checkOutput("B.m_src", m_srcB, expB[0].src);
            checkOutput("B.m_dst", m_dstB, expB[0].dst);
            if (m_treadyB) void'(expB.pop_front());
         end
      end
   end

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      waitCycles(3);
      arst = 1'b0;
      waitCycles(1);

      // Reset mid-stream with five stored beats and a nonzero drop count.
      m_treadyA = 1'b0;
      applyStimulusA(64'hDEAD, 8'h11, 8'h99);
      for (int i = 0; i < 5; i++) applyStimulusA(64'h100 + 64'(i), 8'h22, ID);
      checkOutput("T1.level_pre", levelA, 5);
      #2;
      arst = 1'b1;
      #1;
      checkOutput("T1.level", levelA, 0);
      checkOutput("T1.m_tvalid", m_tvalidA, 0);
      checkOutput("T1.s_tready", s_treadyA, 0);
      checkOutput("T1.drop_cnt", drop_cntA, 0);
      expA.delete();
      dropA = 0;
      waitCycles(1);
      arst = 1'b0;
      waitCycles(1);
      checkOutput("T1.s_tready_release", s_treadyA, 1);

      // Filter: only dst 03 beats survive.
      applyStimulusA(64'd1, 8'h10, 8'h03);
      applyStimulusA(64'd2, 8'h10, 8'h07);
      applyStimulusA(64'd3, 8'h10, 8'h03);
      applyStimulusA(64'd4, 8'h10, 8'hFF);
      checkOutput("T2.drop_cnt", drop_cntA, 2);
      checkOutput("T2.level", levelA, 2);
      checkOutput("T2.head_data", m_tdataA, 64'd1);
      drainA();

      // Back-pressure: fill to 8, a ninth beat must stall.
      m_treadyA = 1'b0;
      for (int i = 0; i < 8; i++) applyStimulusA(64'h300 + 64'(i), 8'h33, ID);
      s_tdataA = 64'h308; s_dstA = ID; s_tvalidA = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("T3.s_tready_full", s_treadyA, 0);
         waitCycles(1);
      end
      checkOutput("T3.level_full", levelA, 8);
      s_tvalidA = 1'b0;
      m_treadyA = 1'b1;
      applyStimulusA(64'h308, 8'h33, ID);
      applyStimulusA(64'h309, 8'h33, ID);
      drainA();

      // Concurrent push and pop hold the level; order kept across pointer wrap.
      m_treadyA = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulusA(64'h400 + 64'(i), 8'h44, ID);
      m_treadyA = 1'b1;
      for (int i = 0; i < 20; i++) applyStimulusA(64'h500 + 64'(i), 8'h55, ID);
      checkOutput("T4.level_steady", levelA, 4);
      drainA();

      fork
         begin
            // Saturate the drop counter on A.
            m_treadyA = 1'b1;
            for (int i = 0; i < 65540; i++) applyStimulusA(64'(i), 8'h66, 8'h55);
            checkOutput("T5.drop_sat", drop_cntA, 16'hFFFF);
            checkOutput("T5.m_tvalid", m_tvalidA, 0);
            waitCycles(2);
            checkOutput("T5.drop_hold", drop_cntA, 16'hFFFF);
         end
         begin
            // Random traffic through B with the filter disabled.
            fork
               begin
                  for (int i = 0; i < 10000; i++) begin
                     logic [7:0] dst;
                     if ($urandom_range(0, 3) == 0) waitCycles(1);
                     dst = ($urandom_range(0, 1) == 0) ? ID : 8'($urandom);
                     applyStimulusB($urandom, 8'($urandom), dst);
                  end
                  doneB = 1'b1;
               end
               begin
                  while (!doneB) begin
                     m_treadyB = ($urandom_range(0, 1) == 1);
                     waitCycles(1);
                  end
               end
            join
            m_treadyB = 1'b1;
            for (int i = 0; i < 50 && levelB != 0; i++) waitCycles(1);
            checkOutput("T6.drain", levelB, 0);
            checkOutput("T6.drop_cnt", drop_cntB, 0);
         end
      join

      waitCycles(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
